// File: rtl/frame_buffer.sv
// Pixel store shared by the rasteriser (writes) and the scan-out (reads).
// Writes outside the frame are clipped. Reads are registered, with one cycle of latency.
// A clear request sweeps every pixel to zero, one address per cycle.
module frame_buffer #(
  parameter int unsigned WIDTH       = 640,
  parameter int unsigned HEIGHT      = 480,
  parameter int unsigned COLOR_DEPTH = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       writeEnable,
  input  logic signed [11:0]         writeX,
  input  logic signed [11:0]         writeY,
  input  logic [3*COLOR_DEPTH-1:0]   writeVal,
  input  logic                       readEnable,
  input  logic [12:0]                readX,
  input  logic [12:0]                readY,
  output logic [3*COLOR_DEPTH-1:0]   readVal,
  input  logic                       clearBuffer
);

  localparam int unsigned PIX_W  = 3 * COLOR_DEPTH;
  localparam int unsigned DEPTH  = WIDTH * HEIGHT;
  localparam int unsigned ADDR_W = $clog2(DEPTH);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   count_q, count_d;

  logic [PIX_W-1:0]    mem [DEPTH];
  logic [PIX_W-1:0]    rd_word_q;
  logic                rd_zero_q, rd_zero_d;

  logic                wr_ok;
  logic                rd_ok;
  logic [ADDR_W-1:0]   wr_addr;
  logic [ADDR_W-1:0]   rd_addr;
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_waddr;
  logic [PIX_W-1:0]    mem_wdata;
  logic                rd_load;

  // Coordinate range checks and linear addresses (y*WIDTH + x)
  always_comb begin
    wr_ok   = (int'(writeX) >= 0) && (int'(writeX) < int'(WIDTH)) &&
              (int'(writeY) >= 0) && (int'(writeY) < int'(HEIGHT));
    rd_ok   = (32'(readX) < WIDTH) && (32'(readY) < HEIGHT);
    wr_addr = ADDR_W'(int'(writeY) * int'(WIDTH) + int'(writeX));
    rd_addr = ADDR_W'(32'(readY) * WIDTH + 32'(readX));
  end

  // Clear FSM next state; clearBuffer is level-sensitive and only sampled in idle
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    case (state_q)
      ST_IDLE: begin
        if (clearBuffer) begin
          state_d = ST_CLEAR;
          count_d = '0;
        end
      end
      ST_CLEAR: begin
        count_d = count_q + ADDR_W'(1);
        if (count_q == ADDR_W'(DEPTH - 1)) begin
          state_d = ST_IDLE;
          count_d = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        count_d = '0;
      end
    endcase
  end

  // Clear FSM state and sweep counter
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  // Memory write port: the sweep owns the port while clearing; a clear request blocks writes
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = wr_addr;
    mem_wdata = writeVal;
    if (!reset) begin
      if (state_q == ST_CLEAR) begin
        mem_we    = 1'b1;
        mem_waddr = count_q;
        mem_wdata = '0;
      end else if (writeEnable && wr_ok && !clearBuffer) begin
        mem_we = 1'b1;
      end
    end
  end

  // Read control: only in-range reads outside a sweep touch the RAM, everything else returns zero
  always_comb begin
    rd_load   = readEnable && rd_ok && (state_q == ST_IDLE);
    rd_zero_d = rd_zero_q;
    if (readEnable) begin
      rd_zero_d = !(rd_ok && (state_q == ST_IDLE));
    end
  end

  // Block RAM: write port plus registered read port (read-before-write)
  always_ff @(posedge clock) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
    if (rd_load) begin
      rd_word_q <= mem[rd_addr];
    end
  end

  // Zero-mask flag for the read data; reset forces readVal to zero
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_zero_q <= 1'b1;
    end else begin
      rd_zero_q <= rd_zero_d;
    end
  end

  assign readVal = rd_zero_q ? '0 : rd_word_q;

endmodule

// File: tb/tb_frame_buffer.sv
// Directed bench for frame_buffer using a reduced 40x30 frame so full sweeps stay short.
module tb_frame_buffer;

  localparam int W     = 40;
  localparam int H     = 30;
  localparam int DEPTH = W * H;

  logic        clock = 1'b0;
  logic        reset;
  logic        writeEnable;
  logic [11:0] writeX;
  logic [11:0] writeY;
  logic [11:0] writeVal;
  logic        readEnable;
  logic [12:0] readX;
  logic [12:0] readY;
  logic [11:0] readVal;
  logic        clearBuffer;

  int n_checks = 0;
  int n_pass   = 0;

  frame_buffer #(.WIDTH(W), .HEIGHT(H), .COLOR_DEPTH(4)) dut (
    .clock       (clock),
    .reset       (reset),
    .writeEnable (writeEnable),
    .writeX      (writeX),
    .writeY      (writeY),
    .writeVal    (writeVal),
    .readEnable  (readEnable),
    .readX       (readX),
    .readY       (readY),
    .readVal     (readVal),
    .clearBuffer (clearBuffer)
  );

  always #5 clock = ~clock;

  // Global time bound
  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, got running required finished");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic write_pix(input int x, input int y, input logic [11:0] v);
    writeEnable = 1'b1;
    writeX      = 12'(x);
    writeY      = 12'(y);
    writeVal    = v;
    tick();
    writeEnable = 1'b0;
  endtask

  task automatic read_pix(input int x, input int y, output logic [11:0] v);
    readEnable = 1'b1;
    readX      = 13'(x);
    readY      = 13'(y);
    tick();
    readEnable = 1'b0;
    v          = readVal;
  endtask

  task automatic pulse_clear();
    clearBuffer = 1'b1;
    tick();
    clearBuffer = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; writeEnable = 1'b0; readEnable = 1'b0; clearBuffer = 1'b0;
    writeX = '0; writeY = '0; writeVal = '0; readX = '0; readY = '0;
    repeat (10) tick();
    reset = 1'b0;
    n_checks++; if (readVal !== 12'h000) $display("FAIL reset_readval: got %h required %h", readVal, 12'h000); else n_pass++;
  endtask

  task automatic test_write_read();
    logic [11:0] v;
    write_pix(1, 1, 12'hABC);
    read_pix(1, 1, v);
    n_checks++; if (v !== 12'hABC) $display("FAIL wr_rd_1_1: got %h required %h", v, 12'hABC); else n_pass++;
    write_pix(0, 0, 12'h321);
    write_pix(W-1, H-1, 12'h9A5);
    read_pix(0, 0, v);
    n_checks++; if (v !== 12'h321) $display("FAIL wr_rd_0_0: got %h required %h", v, 12'h321); else n_pass++;
    read_pix(W-1, H-1, v);
    n_checks++; if (v !== 12'h9A5) $display("FAIL wr_rd_corner: got %h required %h", v, 12'h9A5); else n_pass++;
  endtask

  task automatic test_clear();
    logic [11:0] v;
    write_pix(1, 1, 12'hFFF);
    pulse_clear();
    repeat (DEPTH-1) tick();
    write_pix(5, 5, 12'h111);   // lands on the final sweep cycle: dropped
    write_pix(5, 6, 12'h222);   // first idle cycle: accepted
    read_pix(1, 1, v);
    n_checks++; if (v !== 12'h000) $display("FAIL clear_1_1: got %h required %h", v, 12'h000); else n_pass++;
    read_pix(W-1, H-1, v);
    n_checks++; if (v !== 12'h000) $display("FAIL clear_corner: got %h required %h", v, 12'h000); else n_pass++;
    read_pix(5, 5, v);
    n_checks++; if (v !== 12'h000) $display("FAIL clear_last_cycle_write: got %h required %h", v, 12'h000); else n_pass++;
    read_pix(5, 6, v);
    n_checks++; if (v !== 12'h222) $display("FAIL clear_first_idle_write: got %h required %h", v, 12'h222); else n_pass++;
  endtask

  task automatic test_clipping();
    logic [11:0] v;
    write_pix(0, 5, 12'hA01);
    write_pix(W-1, 0, 12'hA02);
    write_pix(0, H-1, 12'hA03);
    write_pix(-1, 5, 12'h123);
    write_pix(W, 0, 12'h123);
    write_pix(0, H, 12'h123);
    read_pix(0, 5, v);
    n_checks++; if (v !== 12'hA01) $display("FAIL clip_0_5: got %h required %h", v, 12'hA01); else n_pass++;
    read_pix(W-1, 0, v);
    n_checks++; if (v !== 12'hA02) $display("FAIL clip_right_0: got %h required %h", v, 12'hA02); else n_pass++;
    read_pix(0, H-1, v);
    n_checks++; if (v !== 12'hA03) $display("FAIL clip_0_bottom: got %h required %h", v, 12'hA03); else n_pass++;
    read_pix(W-1, 4, v);        // alias of (-1,5)
    n_checks++; if (v !== 12'h000) $display("FAIL clip_alias_neg: got %h required %h", v, 12'h000); else n_pass++;
    read_pix(0, 1, v);          // alias of (W,0)
    n_checks++; if (v !== 12'h000) $display("FAIL clip_alias_wide: got %h required %h", v, 12'h000); else n_pass++;
  endtask

  task automatic test_read_range_hold();
    logic [11:0] v;
    write_pix(0, 1, 12'h4B4);
    read_pix(0, 5, v);
    n_checks++; if (v !== 12'hA01) $display("FAIL rd_pre: got %h required %h", v, 12'hA01); else n_pass++;
    read_pix(700, 10, v);
    n_checks++; if (v !== 12'h000) $display("FAIL rd_out_700_10: got %h required %h", v, 12'h000); else n_pass++;
    read_pix(0, 1, v);
    read_pix(W, 0, v);          // would alias (0,1) if unchecked
    n_checks++; if (v !== 12'h000) $display("FAIL rd_out_x_eq_w: got %h required %h", v, 12'h000); else n_pass++;
    read_pix(0, 5, v);
    readX = 13'd700; readY = 13'd3;
    tick();
    n_checks++; if (readVal !== 12'hA01) $display("FAIL rd_hold_1: got %h required %h", readVal, 12'hA01); else n_pass++;
    readX = 13'd1; readY = 13'd1;
    tick();
    n_checks++; if (readVal !== 12'hA01) $display("FAIL rd_hold_2: got %h required %h", readVal, 12'hA01); else n_pass++;
  endtask

  task automatic test_read_before_write();
    logic [11:0] v;
    write_pix(7, 7, 12'h111);
    readEnable = 1'b1; readX = 13'd7; readY = 13'd7;
    writeEnable = 1'b1; writeX = 12'd7; writeY = 12'd7; writeVal = 12'h222;
    tick();
    readEnable = 1'b0; writeEnable = 1'b0;
    n_checks++; if (readVal !== 12'h111) $display("FAIL rbw_old: got %h required %h", readVal, 12'h111); else n_pass++;
    read_pix(7, 7, v);
    n_checks++; if (v !== 12'h222) $display("FAIL rbw_new: got %h required %h", v, 12'h222); else n_pass++;
  endtask

  task automatic test_during_clear();
    logic [11:0] v;
    write_pix(1, 1, 12'h777);
    pulse_clear();
    repeat (20) tick();
    read_pix(1, 1, v);          // not yet swept, still reads zero
    n_checks++; if (v !== 12'h000) $display("FAIL mid_clear_read: got %h required %h", v, 12'h000); else n_pass++;
    write_pix(2, 2, 12'h555);
    write_pix(0, 0, 12'h556);   // address already swept
    repeat (DEPTH) tick();
    read_pix(2, 2, v);
    n_checks++; if (v !== 12'h000) $display("FAIL mid_clear_wr_2_2: got %h required %h", v, 12'h000); else n_pass++;
    read_pix(0, 0, v);
    n_checks++; if (v !== 12'h000) $display("FAIL mid_clear_wr_0_0: got %h required %h", v, 12'h000); else n_pass++;
  endtask

  task automatic test_reset_mid_clear();
    logic [11:0] v;
    write_pix(W-1, H-1, 12'h3C3);
    read_pix(W-1, H-1, v);
    n_checks++; if (v !== 12'h3C3) $display("FAIL rmc_pre: got %h required %h", v, 12'h3C3); else n_pass++;
    clearBuffer = 1'b1;
    writeEnable = 1'b1; writeX = 12'(W-1); writeY = 12'(H-1); writeVal = 12'h5A5;
    tick();
    clearBuffer = 1'b0; writeEnable = 1'b0;
    repeat (5) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_checks++; if (readVal !== 12'h000) $display("FAIL rmc_readval: got %h required %h", readVal, 12'h000); else n_pass++;
    write_pix(3, 3, 12'h0F0);
    read_pix(3, 3, v);
    n_checks++; if (v !== 12'h0F0) $display("FAIL rmc_write_3_3: got %h required %h", v, 12'h0F0); else n_pass++;
    read_pix(W-1, H-1, v);
    n_checks++; if (v !== 12'h3C3) $display("FAIL rmc_unswept: got %h required %h", v, 12'h3C3); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [11:0] v;
    clearBuffer = 1'b1;
    tick();
    repeat (DEPTH) tick();      // first sweep done; request still high
    tick();                     // second sweep starts here
    clearBuffer = 1'b0;
    tick();
    write_pix(W-1, H-1, 12'hBEE);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    read_pix(W-1, H-1, v);
    n_checks++; if (v !== 12'h000) $display("FAIL b2b_second_sweep: got %h required %h", v, 12'h000); else n_pass++;
    read_pix(3, 3, v);
    n_checks++; if (v !== 12'h000) $display("FAIL b2b_first_sweep: got %h required %h", v, 12'h000); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_clear();
    test_clipping();
    test_read_range_hold();
    test_read_before_write();
    test_during_clear();
    test_reset_mid_clear();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
